// File: rtl/banked_mem_loader.sv
// banked_mem_loader
// Image memory split across NUM_BANKS byte banks with one parameter bank.
// A length-prefixed byte stream is interleaved across the image banks
// (byte i -> bank i mod NUM_BANKS, address i / NUM_BANKS) or written
// linearly into the parameter bank. All banks have registered,
// read-before-write read ports that are independent of the loader.
module banked_mem_loader #(
  parameter int NUM_BANKS   = 4,
  parameter int DATA_W      = 8,
  parameter int IMG_DEPTH   = 1024,
  parameter int PARAM_DEPTH = 32768,
  parameter int LEN_W       = 16,
  localparam int IMG_AW     = $clog2(IMG_DEPTH),
  localparam int PARAM_AW   = $clog2(PARAM_DEPTH),
  localparam int BSEL_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_start,
  input  logic                          load_region,
  input  logic [LEN_W-1:0]              load_len,
  input  logic                          wr_valid,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic                          busy,
  output logic                          load_done,
  output logic                          overflow,
  input  logic                          img_rd_en,
  input  logic [IMG_AW-1:0]             img_rd_addr,
  output logic [NUM_BANKS*DATA_W-1:0]   img_rd_data,
  output logic                          img_rd_valid,
  input  logic                          param_rd_en,
  input  logic [PARAM_AW-1:0]           param_rd_addr,
  output logic [DATA_W-1:0]             param_rd_data,
  output logic                          param_rd_valid
);

  // Address counter is shared by both regions, so it is as wide as the larger one.
  localparam int CNT_AW = (IMG_AW > PARAM_AW) ? IMG_AW : PARAM_AW;
  localparam logic [LEN_W-1:0]  IMG_CAP   = LEN_W'(NUM_BANKS * IMG_DEPTH);
  localparam logic [LEN_W-1:0]  PARAM_CAP = LEN_W'(PARAM_DEPTH);
  localparam logic [BSEL_W-1:0] BANK_LAST = BSEL_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_reg;
  logic                region_reg;
  logic [LEN_W-1:0]    eff_len_reg;
  logic [LEN_W-1:0]    beat_cnt_reg;
  logic [BSEL_W-1:0]   bank_cnt_reg;
  logic [CNT_AW-1:0]   addr_cnt_reg;
  logic                wr_ready_reg;
  logic                busy_reg;
  logic                load_done_reg;
  logic                overflow_reg;
  logic                img_rd_valid_reg;
  logic                param_rd_valid_reg;
  logic [DATA_W-1:0]   param_rd_data_reg;

  logic [LEN_W-1:0]    cap_sel;
  logic [LEN_W-1:0]    eff_len;
  logic                len_over;
  logic                beat_accept;
  logic                bank_wrap;
  logic                last_beat;
  logic                img_we;
  logic                param_we;
  logic [IMG_AW-1:0]   img_wr_addr;
  logic [PARAM_AW-1:0] param_wr_addr;

  // Clamp the requested length to the capacity of the selected region.
  always_comb begin
    cap_sel  = load_region ? PARAM_CAP : IMG_CAP;
    len_over = (load_len > cap_sel);
    eff_len  = len_over ? cap_sel : load_len;
  end

  // A beat in the reset cycle is dropped so an aborted load writes nothing further.
  assign beat_accept   = wr_valid && wr_ready_reg && !reset;
  assign bank_wrap     = (bank_cnt_reg == BANK_LAST);
  assign last_beat     = (beat_cnt_reg == (eff_len_reg - 1'b1));
  assign img_we        = beat_accept && !region_reg;
  assign param_we      = beat_accept && region_reg;
  assign img_wr_addr   = addr_cnt_reg[IMG_AW-1:0];
  assign param_wr_addr = addr_cnt_reg[PARAM_AW-1:0];

  // Loader FSM: latches the load request, walks the bank/address counters
  // and drives the registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      region_reg    <= 1'b0;
      eff_len_reg   <= '0;
      beat_cnt_reg  <= '0;
      bank_cnt_reg  <= '0;
      addr_cnt_reg  <= '0;
      wr_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      load_done_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      load_done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (load_start) begin
            region_reg   <= load_region;
            eff_len_reg  <= eff_len;
            overflow_reg <= len_over;
            beat_cnt_reg <= '0;
            bank_cnt_reg <= '0;
            addr_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            if (eff_len == '0) begin
              state_reg     <= S_DONE;
              load_done_reg <= 1'b1;
            end else begin
              state_reg    <= S_LOAD;
              wr_ready_reg <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (beat_accept) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (region_reg) begin
              addr_cnt_reg <= addr_cnt_reg + 1'b1;
            end else if (bank_wrap) begin
              bank_cnt_reg <= '0;
              addr_cnt_reg <= addr_cnt_reg + 1'b1;
            end else begin
              bank_cnt_reg <= bank_cnt_reg + 1'b1;
            end
            if (last_beat) begin
              state_reg     <= S_DONE;
              wr_ready_reg  <= 1'b0;
              load_done_reg <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg    <= S_IDLE;
          wr_ready_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  // Image banks: each bank owns its storage and its own read data register.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [IMG_DEPTH];
      logic [DATA_W-1:0] rd_data_reg;
      logic              bank_we;

      assign bank_we = img_we && (bank_cnt_reg == BSEL_W'(gi));

      // Write port driven by the stream loader.
      always_ff @(posedge clk) begin
        if (bank_we) begin
          mem[img_wr_addr] <= wr_data;
        end
      end

      // Registered read; holds its value while no read is requested.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data_reg <= '0;
        end else if (img_rd_en) begin
          rd_data_reg <= mem[img_rd_addr];
        end
      end

      assign img_rd_data[gi*DATA_W +: DATA_W] = rd_data_reg;
    end
  endgenerate

  // Parameter bank storage.
  logic [DATA_W-1:0] param_mem [PARAM_DEPTH];

  // Parameter write port driven by the stream loader.
  always_ff @(posedge clk) begin
    if (param_we) begin
      param_mem[param_wr_addr] <= wr_data;
    end
  end

  // Parameter registered read; holds its value while no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      param_rd_data_reg <= '0;
    end else if (param_rd_en) begin
      param_rd_data_reg <= param_mem[param_rd_addr];
    end
  end

  // Read valid flags are the read enables delayed by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      img_rd_valid_reg   <= 1'b0;
      param_rd_valid_reg <= 1'b0;
    end else begin
      img_rd_valid_reg   <= img_rd_en;
      param_rd_valid_reg <= param_rd_en;
    end
  end

  assign wr_ready       = wr_ready_reg;
  assign busy           = busy_reg;
  assign load_done      = load_done_reg;
  assign overflow       = overflow_reg;
  assign img_rd_valid   = img_rd_valid_reg;
  assign param_rd_valid = param_rd_valid_reg;
  assign param_rd_data  = param_rd_data_reg;

endmodule

// File: tb/tb_banked_mem_loader.sv
// Scoreboard bench for banked_mem_loader with default parameters.
// Reads push their expected data into queues; a negedge monitor pops and
// compares whenever a read valid appears.
module tb_banked_mem_loader;

  localparam int NUM_BANKS = 4;
  localparam int DATA_W    = 8;
  localparam int IMG_AW    = 10;
  localparam int PARAM_AW  = 15;
  localparam int LEN_W     = 16;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        load_start;
  logic                        load_region;
  logic [LEN_W-1:0]            load_len;
  logic                        wr_valid;
  logic [DATA_W-1:0]           wr_data;
  logic                        wr_ready;
  logic                        busy;
  logic                        load_done;
  logic                        overflow;
  logic                        img_rd_en;
  logic [IMG_AW-1:0]           img_rd_addr;
  logic [NUM_BANKS*DATA_W-1:0] img_rd_data;
  logic                        img_rd_valid;
  logic                        param_rd_en;
  logic [PARAM_AW-1:0]         param_rd_addr;
  logic [DATA_W-1:0]           param_rd_data;
  logic                        param_rd_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] img_exp_q[$];
  logic [7:0]  param_exp_q[$];
  logic [31:0] img_e;
  logic [7:0]  param_e;

  banked_mem_loader dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .load_region    (load_region),
    .load_len       (load_len),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .busy           (busy),
    .load_done      (load_done),
    .overflow       (overflow),
    .img_rd_en      (img_rd_en),
    .img_rd_addr    (img_rd_addr),
    .img_rd_data    (img_rd_data),
    .img_rd_valid   (img_rd_valid),
    .param_rd_en    (param_rd_en),
    .param_rd_addr  (param_rd_addr),
    .param_rd_data  (param_rd_data),
    .param_rd_valid (param_rd_valid)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %s: got %0h expected %0h ok", name, act, exp);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops one expectation per presented read result.
  always @(negedge clk) begin
    if (!reset) begin
      if (img_rd_valid) begin
        if (img_exp_q.size() == 0) begin
          check("img_rd_unexpected", 64'd1, 64'd0);
        end else begin
          img_e = img_exp_q.pop_front();
          check("img_rd_data", 64'(img_rd_data), 64'(img_e));
        end
      end
      if (param_rd_valid) begin
        if (param_exp_q.size() == 0) begin
          check("param_rd_unexpected", 64'd1, 64'd0);
        end else begin
          param_e = param_exp_q.pop_front();
          check("param_rd_data", 64'(param_rd_data), 64'(param_e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic img_read(input int addr, input logic [31:0] exp);
    img_rd_en   = 1'b1;
    img_rd_addr = IMG_AW'(addr);
    img_exp_q.push_back(exp);
    tick();
    img_rd_en = 1'b0;
  endtask

  task automatic param_read(input int addr, input logic [7:0] exp);
    param_rd_en   = 1'b1;
    param_rd_addr = PARAM_AW'(addr);
    param_exp_q.push_back(exp);
    tick();
    param_rd_en = 1'b0;
  endtask

  // Runs one load; byte k of the stream is base+k. Cycle 0 is the start cycle.
  task automatic run_load(input bit region, input int len, input logic [7:0] base,
                          input bit toggle, input int restart_cyc,
                          input int prd_cyc, input int prd_addr, input logic [7:0] prd_exp,
                          output int accepts, output int done_cyc, output bit saw_ready,
                          output bit ovf, output bit ready_at_done);
    int cyc;
    int bound;
    accepts       = 0;
    done_cyc      = -1;
    saw_ready     = 1'b0;
    ovf           = 1'b0;
    ready_at_done = 1'b1;
    bound         = 2 * len + 20;
    load_start    = 1'b1;
    load_region   = region;
    load_len      = LEN_W'(len);
    tick();
    load_start = 1'b0;
    cyc = 1;
    while (cyc < bound) begin
      if (load_done) begin
        done_cyc      = cyc;
        ovf           = overflow;
        ready_at_done = wr_ready;
        break;
      end
      if (wr_ready) saw_ready = 1'b1;
      wr_valid = toggle ? ((cyc % 2) == 1) : 1'b1;
      wr_data  = 8'(int'(base) + accepts);
      if (cyc == restart_cyc) begin
        load_start  = 1'b1;
        load_len    = LEN_W'(1);
        load_region = ~region;
      end else begin
        load_start = 1'b0;
      end
      if (cyc == prd_cyc) begin
        param_rd_en   = 1'b1;
        param_rd_addr = PARAM_AW'(prd_addr);
        param_exp_q.push_back(prd_exp);
      end else begin
        param_rd_en = 1'b0;
      end
      if (wr_valid && wr_ready) accepts++;
      tick();
      cyc++;
    end
    wr_valid    = 1'b0;
    load_start  = 1'b0;
    param_rd_en = 1'b0;
    if (done_cyc < 0) check("load_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  acc;
    int  dc;
    bit  sr;
    bit  ov;
    bit  rd;
    int  pre_acc;

    reset         = 1'b1;
    load_start    = 1'b0;
    load_region   = 1'b0;
    load_len      = '0;
    wr_valid      = 1'b0;
    wr_data       = '0;
    img_rd_en     = 1'b0;
    img_rd_addr   = '0;
    param_rd_en   = 1'b0;
    param_rd_addr = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_img_rd_valid", 64'(img_rd_valid), 64'd0);
    check("rst_param_rd_valid", 64'(param_rd_valid), 64'd0);
    check("rst_img_rd_data", 64'(img_rd_data), 64'd0);
    check("rst_param_rd_data", 64'(param_rd_data), 64'd0);

    // Image interleave: 8 bytes 0x10..0x17
    run_load(1'b0, 8, 8'h10, 1'b0, -1, -1, 0, 8'h00, acc, dc, sr, ov, rd);
    check("img8_accepts", 64'(acc), 64'd8);
    check("img8_done_cycle", 64'(dc), 64'd9);
    check("img8_overflow", 64'(ov), 64'd0);
    tick();
    check("img8_single_done", 64'(load_done), 64'd0);
    check("img8_busy_cleared", 64'(busy), 64'd0);
    img_read(0, 32'h13121110);
    img_read(1, 32'h17161514);
    tick();
    check("img_hold_valid", 64'(img_rd_valid), 64'd0);
    check("img_hold_data", 64'(img_rd_data), 64'h17161514);

    // Parameter load with wr_valid toggling
    run_load(1'b1, 5, 8'hA0, 1'b1, -1, -1, 0, 8'h00, acc, dc, sr, ov, rd);
    check("par5_accepts", 64'(acc), 64'd5);
    check("par5_done_cycle", 64'(dc), 64'd10);
    check("par5_overflow", 64'(ov), 64'd0);
    tick();
    check("par5_single_done", 64'(load_done), 64'd0);
    check("par5_busy_cleared", 64'(busy), 64'd0);
    param_read(4, 8'hA4);
    param_read(0, 8'hA0);
    tick();

    // Read-during-write on param addr 2: 0x55 then overwritten with 0x66
    run_load(1'b1, 3, 8'h53, 1'b0, -1, -1, 0, 8'h00, acc, dc, sr, ov, rd);
    tick();
    run_load(1'b1, 3, 8'h64, 1'b0, -1, 3, 2, 8'h55, acc, dc, sr, ov, rd);
    check("rdw_accepts", 64'(acc), 64'd3);
    tick();
    param_read(2, 8'h66);
    param_read(0, 8'h64);
    tick();

    // Zero-length load
    run_load(1'b0, 0, 8'h00, 1'b0, -1, -1, 0, 8'h00, acc, dc, sr, ov, rd);
    check("zero_done_cycle", 64'(dc), 64'd1);
    check("zero_ready_seen", 64'(sr), 64'd0);
    check("zero_accepts", 64'(acc), 64'd0);
    tick();
    check("zero_busy_cleared", 64'(busy), 64'd0);

    // Second load_start during LOAD is ignored (length and region kept)
    run_load(1'b0, 4, 8'h30, 1'b0, 2, -1, 0, 8'h00, acc, dc, sr, ov, rd);
    check("restart_accepts", 64'(acc), 64'd4);
    check("restart_done_cycle", 64'(dc), 64'd5);
    tick();
    img_read(0, 32'h33323130);
    img_read(1, 32'h17161514);
    tick();

    // Reset after 3 of 8 image beats
    load_start  = 1'b1;
    load_region = 1'b0;
    load_len    = LEN_W'(8);
    tick();
    load_start = 1'b0;
    wr_valid   = 1'b1;
    pre_acc    = 0;
    for (int k = 0; k < 3; k++) begin
      wr_data = 8'(8'h80 + k);
      if (wr_ready) pre_acc++;
      tick();
    end
    check("rst_mid_pre_accepts", 64'(pre_acc), 64'd3);
    wr_valid    = 1'b0;
    reset       = 1'b1;
    img_rd_en   = 1'b1;
    param_rd_en = 1'b1;
    tick();
    reset       = 1'b0;
    img_rd_en   = 1'b0;
    param_rd_en = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_load_done", 64'(load_done), 64'd0);
    check("rst_mid_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_mid_img_valid", 64'(img_rd_valid), 64'd0);
    check("rst_mid_param_valid", 64'(param_rd_valid), 64'd0);
    run_load(1'b0, 2, 8'hC0, 1'b0, -1, -1, 0, 8'h00, acc, dc, sr, ov, rd);
    check("post_rst_accepts", 64'(acc), 64'd2);
    check("post_rst_done_cycle", 64'(dc), 64'd3);
    tick();
    img_read(0, 32'h3382C1C0);
    img_read(1, 32'h17161514);
    tick();

    // Overflow clamp: 4097 requested, 4096 accepted, byte k = k mod 256
    run_load(1'b0, 4097, 8'h00, 1'b0, -1, -1, 0, 8'h00, acc, dc, sr, ov, rd);
    check("ovf_flag", 64'(ov), 64'd1);
    check("ovf_accepts", 64'(acc), 64'd4096);
    check("ovf_done_cycle", 64'(dc), 64'd4097);
    check("ovf_ready_after", 64'(rd), 64'd0);
    tick();
    check("ovf_sticky", 64'(overflow), 64'd1);
    img_read(1023, 32'hFFFEFDFC);
    img_read(0, 32'h03020100);
    repeat (3) tick();

    check("img_queue_drained", 64'(img_exp_q.size()), 64'd0);
    check("param_queue_drained", 64'(param_exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/banked_mem_loader.md
# banked_mem_loader

Parametrised on-chip memory subsystem for the CNN accelerator. It holds the input image across NUM_BANKS parallel byte banks, and convolution/dense parameters in one parameter bank. A built-in stream loader replaces per-bank write enables: it takes a length-prefixed byte stream from the host and interleaves the bytes across banks. It sits between the host write interface and the compute datapath, which reads all image banks in parallel through independent read ports.

## Interface
- NUM_BANKS, 4, image bank count; power of two, ≥1
- DATA_W, 8, bits per stored word
- IMG_DEPTH, 1024, words per image bank; power of two
- PARAM_DEPTH, 32768, words in parameter bank; power of two
- LEN_W, 16, load-length width; ≥ clog2(max(NUM_BANKS*IMG_DEPTH, PARAM_DEPTH)+1)
- Derived: IMG_AW = clog2(IMG_DEPTH), PARAM_AW = clog2(PARAM_DEPTH), BSEL_W = max(1, clog2(NUM_BANKS))

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- load_start  in  1  one-cycle pulse that begins a load
- load_region  in  1  0 = image banks, 1 = parameter bank; sampled with load_start
- load_len  in  LEN_W  number of bytes to load; sampled with load_start
- wr_valid  in  1  stream beat valid
- wr_data  in  DATA_W  stream beat data
- wr_ready  out  1  loader accepts a beat
- busy  out  1  loader not IDLE
- load_done  out  1  one-cycle pulse when a load completes
- overflow  out  1  sticky; last load_len exceeded region capacity
- img_rd_en  in  1  image read request
- img_rd_addr  in  IMG_AW  word address, same for all banks
- img_rd_data  out  NUM_BANKS*DATA_W  bank k occupies bits [k*DATA_W +: DATA_W]
- img_rd_valid  out  1  img_rd_data is valid
- param_rd_en  in  1  parameter read request
- param_rd_addr  in  PARAM_AW  parameter address
- param_rd_data  out  DATA_W  parameter data
- param_rd_valid  out  1  param_rd_data is valid

## Operation
- States are IDLE, LOAD and DONE. All state changes are clocked on clk.
- In IDLE, load_start=1 does the following:
  - latch region into a register;
  - latch eff_len = min(load_len, cap), where cap = NUM_BANKS*IMG_DEPTH for image and PARAM_DEPTH for param;
  - set overflow = (load_len > cap); otherwise clear overflow;
  - clear the bank counter and address counter.
- Next state after load_start is DONE if eff_len == 0, otherwise LOAD.
- load_start is ignored in LOAD and DONE.
- In LOAD, wr_ready=1. A beat is accepted when wr_valid && wr_ready.
- Image region write placement:
  - the byte goes to bank bank_cnt at address addr_cnt;
  - bank_cnt increments and wraps at NUM_BANKS;
  - addr_cnt increments when bank_cnt wraps.
  - Byte index i therefore lands in bank i mod NUM_BANKS at address i / NUM_BANKS.
  - No divider is used.
- Parameter region write placement: the byte goes to address addr_cnt, and addr_cnt increments every beat.
- When the accepted beat is beat number eff_len, the next state is DONE.
- DONE lasts exactly one cycle with load_done=1, then returns to IDLE.
- Beats beyond eff_len are not accepted, because wr_ready=0 outside LOAD. The producer must stall.
- Read ports are independent of the loader and usable in any state.
- Reading an address in the same cycle it is written returns the old data (read-before-write).
- Out-of-range cannot occur because address widths are exact.

## Timing
- Reset values:
  - state IDLE;
  - wr_ready=0, busy=0, load_done=0, overflow=0;
  - img_rd_valid=0, param_rd_valid=0;
  - img_rd_data=0, param_rd_data=0;
  - counters 0.
- Memory contents are not cleared by reset.
- Reset asserted mid-load aborts the load: no load_done, and bytes already written stay in memory.
- The write takes effect at the clk edge where the beat is accepted.
- A load of N bytes with wr_valid held high has these cycles:
  - load_start at cycle 0;
  - LOAD and wr_ready=1 during cycles 1..N;
  - load_done at cycle N+1;
  - busy=0 at cycle N+2.
  - busy=1 during cycles 1..N+1.
- Read latency is 1 cycle. Request at cycle t gives data and rd_valid=1 at cycle t+1.
- rd_valid is simply rd_en delayed by one cycle. Back-to-back reads give one result per cycle.
- When rd_en=0, rd_data holds its last value and rd_valid=0.
- wr_valid may drop mid-load. The loader waits in LOAD indefinitely without a timeout.

## Test plan
- Image load interleave: load_region=0, load_len=8, bytes 0x10..0x17, then read addr 0 and addr 1.
  - Expect img_rd_data = {0x13,0x12,0x11,0x10}, then {0x17,0x16,0x15,0x14}.
  - Expect load_done at cycle 9 and overflow=0.
- Parameter load with stalls: load_len=5, bytes 0xA0..0xA4, wr_valid toggling every cycle.
  - Expect exactly 5 accepts and one load_done pulse.
  - Expect param_rd_addr=4 to return 0xA4 one cycle after request.
- Overflow clamp: image load_len=4097 with defaults.
  - Expect overflow=1 and exactly 4096 beats accepted.
  - Expect the last byte 0xFF at bank 3 addr 1023, then wr_ready=0.
- Zero length and ignored start: load_len=0 gives load_done one cycle after start, with wr_ready never 1.
  - A second load_start during LOAD does not change the latched length.
- Read-during-write: param addr 2 holds 0x55. In the same cycle, write 0x66 to it via the loader and read it.
  - Expect the read to return 0x55.
  - Expect the next read to return 0x66.
- Reset mid-load: assert reset after 3 of 8 beats.
  - Expect busy=0, no load_done and all rd_valid=0 on the next cycle.
  - A new 2-byte load then writes from bank 0, addr 0.
